// File: rtl/secuencia_escritura.sv
// Write sequencer for the RTC register block: walks indices 1..N_REG, handing one
// byte per index to the bus timing controller, with a per-register timeout.
module secuencia_escritura #(
  parameter int N_REG    = 8,
  parameter int T_ESPERA = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] datos,
  input  logic        bus_done,
  output logic [3:0]  binary_out,
  output logic        EN_dir,
  output logic [7:0]  dato_out,
  output logic        bus_req,
  output logic        ocupado,
  output logic        fin,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, CARGA, PEDIR, ESPERA, PAUSA, FIN} state_t;

  localparam logic [3:0] LAST_IDX = 4'(N_REG);
  localparam logic [7:0] CNT_LAST = 8'(T_ESPERA - 1);

  state_t      state_q, state_d;
  logic [63:0] snap_q, snap_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        error_q, error_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    case (state_q)
      IDLE: if (start) state_d = CARGA;
      CARGA: begin
        snap_d  = datos;
        idx_d   = 4'd1;
        error_d = 1'b0;
        cnt_d   = '0;
        state_d = PEDIR;
      end
      PEDIR: state_d = ESPERA;
      ESPERA: begin
        // A bus_done on the last allowed cycle wins over the timeout.
        if (bus_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = PAUSA;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = cnt_q + 8'd1;
          error_d = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PAUSA: begin
        cnt_d   = '0;
        state_d = PEDIR;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic       addr_en;
  logic [2:0] byte_sel;

  // Index k maps to byte k-1; index 8 wraps to select 7 through the 3-bit subtract.
  assign byte_sel   = idx_q[2:0] - 3'd1;
  assign addr_en    = (state_q == PEDIR) || (state_q == ESPERA) || (state_q == PAUSA);
  assign EN_dir     = addr_en;
  assign binary_out = addr_en ? idx_q : 4'd0;
  assign dato_out   = addr_en ? snap_q[{byte_sel, 3'b000} +: 8] : 8'h00;
  assign bus_req    = (state_q == PEDIR) || (state_q == ESPERA);
  assign ocupado    = (state_q != IDLE);
  assign fin        = (state_q == FIN);
  assign error      = error_q;

endmodule

// File: tb/tb_secuencia_escritura.sv
// Randomized bench for secuencia_escritura: a timeline model expands each planned
// sequence (payload + per-register bus_done delay) into expected per-cycle outputs.
module tb_secuencia_escritura;
  localparam int N = 8;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset, start, bus_done;
  logic [63:0] datos;
  logic [3:0]  binary_out;
  logic        EN_dir, bus_req, ocupado, fin, error;
  logic [7:0]  dato_out;

  secuencia_escritura #(.N_REG(N), .T_ESPERA(T)) dut (
    .clk(clk), .reset(reset), .start(start), .datos(datos), .bus_done(bus_done),
    .binary_out(binary_out), .EN_dir(EN_dir), .dato_out(dato_out),
    .bus_req(bus_req), .ocupado(ocupado), .fin(fin), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] idx;
    logic       en;
    logic [7:0] dato;
    logic       req;
    logic       oc;
    logic       fin;
    logic       err;
  } obs_t;

  obs_t exp_q[$];
  logic st_q[$], dn_q[$], esp_q[$], cap_q[$];
  int   dly[N];
  logic err_model;
  int   n_cmp, n_bad;

  function automatic obs_t observe();
    obs_t o;
    o.idx = binary_out; o.en = EN_dir; o.dato = dato_out; o.req = bus_req;
    o.oc = ocupado; o.fin = fin; o.err = error;
    return o;
  endfunction

  function automatic obs_t mk(int idx, bit en, logic [7:0] d, bit req, bit oc, bit f, logic e);
    obs_t o;
    o.idx = 4'(idx); o.en = en; o.dato = d; o.req = req; o.oc = oc; o.fin = f; o.err = e;
    return o;
  endfunction

  // Expand one sequence into its cycle timeline: what the outputs must be and what
  // the bench drives on start/bus_done in each cycle.
  task automatic plan(input logic [63:0] d, input bit hold);
    bit junk_st;
    exp_q.delete(); st_q.delete(); dn_q.delete(); esp_q.delete(); cap_q.delete();
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, err_model));
    st_q.push_back(1'b1); dn_q.push_back(1'($urandom_range(0, 1))); esp_q.push_back(0); cap_q.push_back(1);
    junk_st = hold ? 1'b1 : 1'($urandom_range(0, 1));
    exp_q.push_back(mk(0, 0, 8'h00, 0, 1, 0, err_model));
    st_q.push_back(junk_st); dn_q.push_back(1'($urandom_range(0, 1))); esp_q.push_back(0); cap_q.push_back(1);
    err_model = 1'b0;
    for (int k = 1; k <= N; k++) begin
      logic [7:0] b;
      b = d[8*k-8 +: 8];
      junk_st = hold ? 1'b1 : 1'($urandom_range(0, 1));
      exp_q.push_back(mk(k, 1, b, 1, 1, 0, 0));
      st_q.push_back(junk_st); dn_q.push_back(1'($urandom_range(0, 1))); esp_q.push_back(0); cap_q.push_back(0);
      if (dly[k-1] >= T) begin
        for (int j = 0; j < T; j++) begin
          exp_q.push_back(mk(k, 1, b, 1, 1, 0, 0));
          st_q.push_back(hold); dn_q.push_back(1'b0); esp_q.push_back(1); cap_q.push_back(0);
        end
        err_model = 1'b1;
        break;
      end
      for (int j = 0; j <= dly[k-1]; j++) begin
        exp_q.push_back(mk(k, 1, b, 1, 1, 0, 0));
        st_q.push_back(hold); dn_q.push_back(j == dly[k-1]); esp_q.push_back(1); cap_q.push_back(0);
      end
      if (k < N) begin
        exp_q.push_back(mk(k + 1, 1, d[8*k +: 8], 0, 1, 0, 0));
        st_q.push_back(hold); dn_q.push_back(1'($urandom_range(0, 1))); esp_q.push_back(0); cap_q.push_back(0);
      end
    end
    exp_q.push_back(mk(0, 0, 8'h00, 0, 1, 1, err_model));
    st_q.push_back(hold); dn_q.push_back(1'($urandom_range(0, 1))); esp_q.push_back(0); cap_q.push_back(0);
  endtask

  // Walk the planned timeline one cycle at a time. Stops early (without advancing)
  // in the first wait cycle of index stop_idx when stop_idx > 0.
  task automatic run_plan(input string name, input logic [63:0] d, input bit ff,
                          input int stop_idx, output int fin_at);
    obs_t o;
    fin_at = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      o = observe();
      n_cmp++;
      if (o !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s cyc%0d: got idx=%0d en=%b dato=%h req=%b oc=%b fin=%b err=%b want idx=%0d en=%b dato=%h req=%b oc=%b fin=%b err=%b",
                 name, i, o.idx, o.en, o.dato, o.req, o.oc, o.fin, o.err,
                 exp_q[i].idx, exp_q[i].en, exp_q[i].dato, exp_q[i].req, exp_q[i].oc, exp_q[i].fin, exp_q[i].err);
      end
      if (o.fin === 1'b1 && fin_at < 0) fin_at = i;
      start    = st_q[i];
      bus_done = dn_q[i];
      datos    = cap_q[i] ? d : (ff ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom});
      if (stop_idx > 0 && esp_q[i] && exp_q[i].idx == 4'(stop_idx)) return;
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_cycles(input string name, input int n);
    obs_t o, e;
    for (int i = 0; i < n; i++) begin
      e = mk(0, 0, 8'h00, 0, 0, 0, err_model);
      o = observe();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s idle%0d: got oc=%b req=%b en=%b fin=%b err=%b want oc=0 req=0 en=0 fin=0 err=%b",
                 name, i, o.oc, o.req, o.en, o.fin, o.err, e.err);
      end
      start = 1'b0; bus_done = 1'($urandom_range(0, 1)); datos = {$urandom, $urandom};
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b0; start = 1'b0; bus_done = 1'b0; datos = '0;
    repeat (2) @(posedge clk);
    #1;
    o = observe();
    n_cmp++;
    if (o !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0", o);
    end
    #3 reset = 1'b1;
    @(posedge clk); #1;
    err_model = 1'b0;
    idle_cycles("after_reset", 2);
  endtask

  task automatic test_normal();
    int fa;
    logic [63:0] d;
    d = 64'h0807060504030201;
    foreach (dly[k]) dly[k] = 0;
    plan(d, 0);
    run_plan("normal", d, 0, 0, fa);
    // Start-sample cycle is cycle 0; fin lands on the (3N+2)-th cycle counted inclusively.
    n_cmp++;
    if (fa != 3 * N + 1) begin
      n_bad++;
      $display("FAIL normal_latency: fin at cycle %0d want %0d", fa, 3 * N + 1);
    end
    idle_cycles("normal_tail", 1);
  endtask

  task automatic test_timeout();
    int fa;
    logic [63:0] d;
    d = {$urandom, $urandom};
    foreach (dly[k]) dly[k] = T + 3;
    plan(d, 0);
    run_plan("timeout", d, 0, 0, fa);
    n_cmp++;
    if (error !== 1'b1 || ocupado !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_flags: got error=%b ocupado=%b want error=1 ocupado=0", error, ocupado);
    end
    idle_cycles("timeout_tail", 2);
  endtask

  task automatic test_boundary();
    int fa;
    logic [63:0] d;
    d = {$urandom, $urandom};
    foreach (dly[k]) dly[k] = T - 1;
    plan(d, 0);
    run_plan("boundary", d, 0, 0, fa);
    n_cmp++;
    if (error !== 1'b0) begin
      n_bad++;
      $display("FAIL boundary_error: got %b want 0", error);
    end
    idle_cycles("boundary_tail", 1);
  endtask

  task automatic test_datos_change();
    int fa;
    logic [63:0] d;
    d = 64'h1122334455667788;
    foreach (dly[k]) dly[k] = $urandom_range(0, T - 1);
    plan(d, 0);
    run_plan("datos_ff", d, 1, 0, fa);
    idle_cycles("datos_tail", 1);
  endtask

  // start held high throughout, including FIN, then a second sequence follows at once.
  task automatic test_back_to_back();
    int fa;
    logic [63:0] d;
    d = {$urandom, $urandom};
    foreach (dly[k]) dly[k] = $urandom_range(0, 2);
    plan(d, 1);
    run_plan("busy_start", d, 0, 0, fa);
    d = {$urandom, $urandom};
    foreach (dly[k]) dly[k] = $urandom_range(0, 2);
    plan(d, 0);
    run_plan("back_to_back", d, 0, 0, fa);
    idle_cycles("b2b_tail", 1);
  endtask

  task automatic test_reset_mid_run();
    int fa;
    obs_t o;
    logic [63:0] d;
    d = {$urandom, $urandom};
    foreach (dly[k]) dly[k] = 2;
    plan(d, 0);
    run_plan("pre_reset", d, 0, 5, fa);
    #2 reset = 1'b0;
    #1;
    o = observe();
    n_cmp++;
    if (o !== obs_t'(0)) begin
      n_bad++;
      $display("FAIL async_reset: got %h want 0", o);
    end
    start = 1'b0; bus_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      o = observe();
      n_cmp++;
      if (o !== obs_t'(0)) begin
        n_bad++;
        $display("FAIL reset_hold%0d: got %h want 0", i, o);
      end
    end
    #3 reset = 1'b1;
    @(posedge clk); #1;
    err_model = 1'b0;
    idle_cycles("post_reset", 3);
    d = {$urandom, $urandom};
    foreach (dly[k]) dly[k] = $urandom_range(0, 1);
    plan(d, 0);
    run_plan("restart", d, 0, 0, fa);
    idle_cycles("restart_tail", 1);
  endtask

  task automatic test_random();
    int fa, r;
    logic [63:0] d;
    for (int s = 0; s < 12; s++) begin
      d = {$urandom, $urandom};
      foreach (dly[k]) begin
        r = $urandom_range(0, 15);
        dly[k] = (r == 15) ? T + r % 3 : r % T;
      end
      plan(d, 1'($urandom_range(0, 1)));
      run_plan("random", d, 1'($urandom_range(0, 1)), 0, fa);
      if ($urandom_range(0, 1) == 1) idle_cycles("random_gap", $urandom_range(1, 3));
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; err_model = 1'b0;
    test_reset();
    test_normal();
    test_timeout();
    test_boundary();
    test_datos_change();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
